// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Adds two WIDTH-bit operands one nibble per clock, least-significant
// nibble first, by driving an external combinational 4-bit adder stage.
// The inter-nibble carry is registered here; the assembled sum, final
// carry and signed overflow are presented on a valid/ready output.
module nibble_serial_adder_ctrl #(
  parameter  int WIDTH   = 16,
  localparam int NIBBLES = WIDTH / 4,
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  // operand side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  // external 4-bit adder stage
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  // result side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_next;
  logic             last_nib;
  logic             ovf_next;

  // Selects nibble n of a WIDTH-bit vector.
  function automatic logic [3:0] nib_of(input logic [WIDTH-1:0] vec, input int n);
    return vec[n*4 +: 4];
  endfunction

  // Two's-complement overflow: like-signed operands yielding a result of
  // the opposite sign. Evaluated on signed views of the MSBs.
  function automatic logic signed_ovf(input logic signed [WIDTH-1:0] a,
                                      input logic signed [WIDTH-1:0] b,
                                      input logic signed [WIDTH-1:0] s);
    return ((a < 0) == (b < 0)) && ((s < 0) != (a < 0));
  endfunction

  assign last_nib  = (idx == IDX_W'(NIBBLES - 1));
  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_RUN) || (state == S_DONE);
  assign ovf_next  = signed_ovf(a_reg, b_reg, sum_next);

  // Present the current nibble pair and carry to the adder stage; quiet otherwise.
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state == S_RUN) begin
      add_a   = nib_of(a_reg, int'(idx));
      add_b   = nib_of(b_reg, int'(idx));
      add_cin = carry_reg;
    end
  end

  // Partial sum with the adder stage's current nibble merged in, so the
  // final nibble is included when the result registers load.
  always_comb begin
    sum_next = sum_reg;
    sum_next[int'(idx)*4 +: 4] = add_sum;
  end

  // Sequencer: IDLE -> RUN (one nibble per cycle) -> DONE -> IDLE on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            state <= S_RUN;
            idx   <= '0;
          end
        end
        S_RUN: begin
          if (last_nib) begin
            state <= S_DONE;
            idx   <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand capture, carry chain and partial-sum assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
    end else begin
      if (state == S_IDLE && in_valid && in_ready) begin
        a_reg     <= in_a;
        b_reg     <= in_b;
        carry_reg <= in_cin;
        sum_reg   <= '0;
      end else if (state == S_RUN) begin
        sum_reg   <= sum_next;
        carry_reg <= add_cout;
      end
    end
  end

  // Result registers load once, on the final nibble, and hold until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (state == S_RUN && last_nib) begin
      out_sum  <= sum_next;
      out_cout <= add_cout;
      out_ovf  <= ovf_next;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Testbench for nibble_serial_adder_ctrl (WIDTH=16) with a behavioural
// 4-bit adder stage and a queue-based scoreboard of expected results.
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout, out_ovf, busy;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // behavioural combinational 4-bit adder stage
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] t;
    exp_t r;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return r;
  endfunction

  // scoreboard: pop on each output handshake
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("sb_sum",  32'(out_sum), 32'(e.sum));
        check_val("sb_cout", 32'(out_cout), 32'(e.cout));
        check_val("sb_ovf",  32'(out_ovf), 32'(e.ovf));
      end
    end
  end

  // Drive operands for one accept edge; optionally record the expected result.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input bit push);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
    check_val("accept_in_ready", 32'(in_ready), 32'd1);
    if (push) sb.push_back(model(a, b, cin));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Step through the RUN nibbles, then confirm out_valid arrives on edge N.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit check_seq);
    logic [4:0] t;
    logic c;
    c = cin;
    for (int i = 0; i < N; i++) begin
      check_val("run_no_valid", 32'(out_valid), 32'd0);
      check_val("run_busy", 32'(busy), 32'd1);
      if (check_seq) begin
        check_val($sformatf("seq_add_a%0d", i), 32'(add_a), 32'((a >> (4*i)) & 16'hF));
        check_val($sformatf("seq_add_b%0d", i), 32'(add_b), 32'((b >> (4*i)) & 16'hF));
        check_val($sformatf("seq_add_cin%0d", i), 32'(add_cin), 32'(c));
      end
      t = 5'((a >> (4*i)) & 16'hF) + 5'((b >> (4*i)) & 16'hF) + 5'(c);
      c = t[4];
      @(posedge clk); #1;
    end
    check_val("latency_out_valid", 32'(out_valid), 32'd1);
    check_val("done_in_ready", 32'(in_ready), 32'd0);
  endtask

  // Accept the result and confirm return to IDLE.
  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("post_hs_out_valid", 32'(out_valid), 32'd0);
    check_val("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic full_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input bit check_seq);
    start_op(a, b, cin, 1'b1);
    run_op(a, b, cin, check_seq);
    finish_op();
  endtask

  initial begin
    exp_t e;

    // 1: asynchronous reset mid-cycle
    #13 rst = 1'b1;
    #1;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_sum", 32'(out_sum), 32'd0);
    check_val("rst_out_cout", 32'(out_cout), 32'd0);
    check_val("rst_out_ovf", 32'(out_ovf), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_add_a", 32'(add_a), 32'd0);
    check_val("rst_add_b", 32'(add_b), 32'd0);
    check_val("rst_add_cin", 32'(add_cin), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_val("rel_in_ready", 32'(in_ready), 32'd1);

    // 2: carry ripple with nibble sequence check
    full_op(16'h00FF, 16'h0001, 1'b0, 1'b1);

    // 3: wrap-around and overflow corners
    full_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    full_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    full_op(16'h8000, 16'h8000, 1'b0, 1'b0);

    // 4: carry-in
    full_op(16'h1234, 16'h4321, 1'b1, 1'b1);

    // 5: backpressure with ignored in_valid pulses
    start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    e = model(16'h0F0F, 16'h00F1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a = 16'hDEAD;
      in_b = 16'hBEEF;
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check_val("bp_out_valid", 32'(out_valid), 32'd1);
      check_val("bp_out_sum", 32'(out_sum), 32'(e.sum));
      check_val("bp_out_cout", 32'(out_cout), 32'(e.cout));
    end
    in_valid = 1'b0;
    finish_op();
    full_op(16'h1111, 16'h2222, 1'b0, 1'b0);

    // 6: reset during RUN discards the operation
    start_op(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_val("abort_no_valid", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    full_op(16'h0001, 16'h0002, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands by driving an external combinational 4-bit adder stage (a, b, c_in in; 4-bit sum, c_out back) one nibble per clock, least-significant nibble first.
- Sits between the terminal's operand-capture logic (valid/ready producer) and the result formatter (valid/ready consumer).
- Registers the inter-nibble carry and assembles the full-width sum, final carry and signed overflow.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8.
- NIBBLES, WIDTH/4, derived; not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  operand A, unsigned / two's complement.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry into nibble 0.
- add_a  out  4  nibble of A to the adder stage.
- add_b  out  4  nibble of B to the adder stage.
- add_cin  out  1  carry to the adder stage.
- add_sum  in  4  sum from the adder stage, combinational from add_*.
- add_cout  in  1  carry from the adder stage.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  full sum.
- out_cout  out  1  carry out of the MSB nibble.
- out_ovf  out  1  signed overflow flag.
- busy  out  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (async, immediate):
  - State goes to IDLE. Nibble index, carry register and operand registers clear to 0.
  - out_valid, out_sum, out_cout, out_ovf, busy, add_a, add_b, add_cin are all 0.
  - in_ready is 0 while rst is high and 1 in IDLE after release.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture in_a, in_b into registers, carry_reg <= in_cin, idx <= 0, go to RUN.
  - in_valid without in_ready is ignored.
- RUN:
  - in_ready=0.
  - add_a = a_reg[4*idx+3:4*idx], add_b = b_reg[4*idx+3:4*idx], add_cin = carry_reg.
  - Each cycle, sum_reg nibble idx <= add_sum, carry_reg <= add_cout, idx <= idx+1.
  - At idx = NIBBLES-1, go to DONE and load the result registers:
    - out_sum from the full assembled sum, including the final nibble.
    - out_cout from add_cout.
    - out_ovf = (a_reg[W-1] == b_reg[W-1]) & (sum[W-1] != a_reg[W-1]).
  - Outside RUN, add_a, add_b and add_cin are driven 0.
- DONE:
  - out_valid=1. out_sum, out_cout and out_ovf are stable until handshake.
  - On out_valid & out_ready: go to IDLE and drop out_valid the next cycle.
  - out_sum, out_cout and out_ovf keep their values until the next result load.
- Latency: an accept at edge k gives out_valid=1 after edge k+NIBBLES. Throughput is at most one operation per NIBBLES+2 cycles.
- No overlap: in_ready stays 0 in DONE even when out_ready=1. A new accept happens no earlier than the cycle after the output handshake.
- Backpressure: out_ready may be held low indefinitely. Outputs hold, and in_valid pulses are ignored.
- Wrap-around: sum is mod 2^WIDTH. Carry out of the MSB appears only on out_cout.
- Reset mid-RUN or mid-DONE: the operation is discarded and no out_valid pulse occurs. The next operation after reset is unaffected by the aborted one.
- Adder stage is purely combinational within one cycle. No registered path through add_* is assumed.

Test Plan (WIDTH=16, bench models the 4-bit adder stage behaviourally):
1. Assert rst mid-cycle, without a clock edge.
   -> All outputs 0 immediately.
   -> in_ready rises to 1 after rst release.
2. Add 0x00FF + 0x0001, cin=0.
   -> add_a/add_b sequence F/1, F/0, 0/0, 0/0 with add_cin 0,1,1,0.
   -> out_valid exactly 4 edges after accept.
   -> out_sum=0x0100, out_cout=0, out_ovf=0.
3. Add 0xFFFF + 0x0001, cin=0.
   -> out_sum=0x0000, out_cout=1, out_ovf=0.
   Add 0x7FFF + 0x0001.
   -> out_sum=0x8000, out_cout=0, out_ovf=1.
   Add 0x8000 + 0x8000.
   -> out_sum=0x0000, out_cout=1, out_ovf=1.
4. Add 0x1234 + 0x4321, cin=1.
   -> out_sum=0x5556, out_cout=0, out_ovf=0.
5. Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid.
   -> out_* stable, in_ready=0, pulse not captured.
   Then raise out_ready.
   -> out_valid low next cycle, in_ready=1, next operand accepted.
6. Assert rst after 2 RUN cycles of 0xAAAA + 0x5555, then release.
   -> No out_valid.
   Then run 0x0001 + 0x0002.
   -> out_sum=0x0003, out_cout=0.
